count_window_sequencer: RTL and testbench

- Sequences gated pulse-counting measurements for the pulse-counting chain.
- Consumes the one-cycle photon-edge strobe produced by the threshold discriminator.
- Runs N back-to-back measurement windows, each preceded by a holdoff. Each window's count goes out on a valid/ready result port.
- Raises a fixed-length trigger pulse to the signal generator when a window's count reaches the user threshold.

---
 rtl/count_window_sequencer.sv | 158 +++++++++++++++
 tb/tb_count_window_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_window_sequencer.sv
// Gated pulse-counting sequencer: runs N holdoff+gate windows, reports each
// window count over a valid/ready port and fires a trigger pulse when a
// window count reaches the configured threshold.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; window_idx/overflow held for readout
// S_HOLDOFF | dead cycles before a gate, edges ignored
// S_GATE    | counting edge_in strobes for the configured window length
// S_REPORT  | result presented, waiting for the downstream handshake
module count_window_sequencer #(
  parameter int COUNT_WIDTH = 32,
  parameter int TIME_WIDTH  = 32,
  parameter int TRIG_WIDTH  = 16,
  parameter int IDX_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   edge_in,
  input  logic [TIME_WIDTH-1:0]  window_len,
  input  logic [TIME_WIDTH-1:0]  holdoff_len,
  input  logic [COUNT_WIDTH-1:0] n_threshold,
  input  logic [IDX_WIDTH-1:0]   n_windows,
  input  logic [TRIG_WIDTH-1:0]  trig_len,
  output logic [COUNT_WIDTH-1:0] result_tdata,
  output logic                   result_tvalid,
  input  logic                   result_tready,
  output logic                   trig_out,
  output logic                   busy,
  output logic [IDX_WIDTH-1:0]   window_idx,
  output logic                   overflow
);

  typedef enum logic [1:0] {S_IDLE, S_HOLDOFF, S_GATE, S_REPORT} state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  state_t state, state_nxt;

  logic [TIME_WIDTH-1:0]  cfg_window, cfg_holdoff;
  logic [COUNT_WIDTH-1:0] cfg_thr;
  logic [IDX_WIDTH-1:0]   cfg_nwin;
  logic [TRIG_WIDTH-1:0]  cfg_trig;

  logic [TIME_WIDTH-1:0]  timer;
  logic [COUNT_WIDTH-1:0] count;
  logic [TRIG_WIDTH-1:0]  trig_cnt;

  logic                   timer_last, cnt_sat, more, fire;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic [TIME_WIDTH-1:0]  next_seg_timer;

  // A zero-length gate still samples one edge.
  function automatic logic [TIME_WIDTH-1:0] win_eff(input logic [TIME_WIDTH-1:0] len);
    return (len == '0) ? TIME_WIDTH'(1) : len;
  endfunction

  assign timer_last     = (timer == TIME_WIDTH'(1));
  assign cnt_sat        = (count == CNT_MAX);
  assign count_inc      = (edge_in && !cnt_sat) ? count + COUNT_WIDTH'(1) : count;
  assign more           = (cfg_nwin == '0) || (window_idx < (cfg_nwin - IDX_WIDTH'(1)));
  assign next_seg_timer = (cfg_holdoff != '0) ? cfg_holdoff : win_eff(cfg_window);
  assign fire           = (state == S_GATE) && timer_last && !abort && (cfg_thr != '0)
                          && (count_inc >= cfg_thr) && (cfg_trig != '0);
  assign busy           = (state != S_IDLE);
  assign trig_out       = (trig_cnt != '0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = (holdoff_len != '0) ? S_HOLDOFF : S_GATE;
      S_HOLDOFF: if (timer_last) state_nxt = S_GATE;
      S_GATE:    if (timer_last) state_nxt = S_REPORT;
      S_REPORT:  if (result_tready)
                   state_nxt = more ? ((cfg_holdoff != '0) ? S_HOLDOFF : S_GATE) : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Configuration latch, phase timer, window counter and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_window    <= '0;
      cfg_holdoff   <= '0;
      cfg_thr       <= '0;
      cfg_nwin      <= '0;
      cfg_trig      <= '0;
      timer         <= '0;
      count         <= '0;
      result_tdata  <= '0;
      result_tvalid <= 1'b0;
      window_idx    <= '0;
      overflow      <= 1'b0;
    end else if (abort) begin
      count         <= '0;
      timer         <= '0;
      result_tvalid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cfg_window  <= window_len;
            cfg_holdoff <= holdoff_len;
            cfg_thr     <= n_threshold;
            cfg_nwin    <= n_windows;
            cfg_trig    <= trig_len;
            window_idx  <= '0;
            overflow    <= 1'b0;
            count       <= '0;
            timer       <= (holdoff_len != '0) ? holdoff_len : win_eff(window_len);
          end
        end
        S_HOLDOFF: timer <= timer_last ? win_eff(cfg_window) : timer - TIME_WIDTH'(1);
        S_GATE: begin
          if (edge_in && cnt_sat) overflow <= 1'b1;
          if (timer_last) begin
            result_tdata  <= count_inc;
            result_tvalid <= 1'b1;
            count         <= '0;
          end else begin
            count <= count_inc;
            timer <= timer - TIME_WIDTH'(1);
          end
        end
        S_REPORT: begin
          if (result_tready) begin
            result_tvalid <= 1'b0;
            if (more) begin
              window_idx <= window_idx + IDX_WIDTH'(1);
              timer      <= next_seg_timer;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Trigger pulse timer; free of the FSM so a pulse outlives its window,
  // and a new fire reloads it so back-to-back pulses merge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                trig_cnt <= '0;
    else if (abort)          trig_cnt <= '0;
    else if (fire)           trig_cnt <= cfg_trig;
    else if (trig_cnt != '0) trig_cnt <= trig_cnt - TRIG_WIDTH'(1);
  end

endmodule

// File: tb/tb_count_window_sequencer.sv
module tb_count_window_sequencer;

  localparam int CW   = 4;
  localparam int TW   = 32;
  localparam int GW   = 16;
  localparam int IW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk, rst, start, abort, edge_in, result_tready;
  logic [TW-1:0] window_len, holdoff_len;
  logic [CW-1:0] n_threshold;
  logic [IW-1:0] n_windows;
  logic [GW-1:0] trig_len;
  logic [CW-1:0] result_tdata;
  logic          result_tvalid, trig_out, busy, overflow;
  logic [IW-1:0] window_idx;

  int checks = 0;
  int errors = 0;

  count_window_sequencer #(
    .COUNT_WIDTH(CW), .TIME_WIDTH(TW), .TRIG_WIDTH(GW), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .edge_in(edge_in),
    .window_len(window_len), .holdoff_len(holdoff_len), .n_threshold(n_threshold),
    .n_windows(n_windows), .trig_len(trig_len), .result_tdata(result_tdata),
    .result_tvalid(result_tvalid), .result_tready(result_tready), .trig_out(trig_out),
    .busy(busy), .window_idx(window_idx), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is a sequence of segments; edge k of a segment
  // (counted from the edge that started it) is holdoff while k <= H and a
  // gate edge while H < k <= H + max(W,1). The result waits for a handshake.
  int  m_h, m_w, m_thr, m_nwin, m_tl;
  int  m_k, m_cnt, m_tdata, m_idx, m_trig;
  bit  m_busy, m_tvalid, m_ovf, m_fire;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_h = 0; m_w = 0; m_thr = 0; m_nwin = 0; m_tl = 0;
      m_k = 0; m_cnt = 0; m_tdata = 0; m_idx = 0; m_trig = 0;
      m_busy = 0; m_tvalid = 0; m_ovf = 0;
    end else begin
      m_fire = 0;
      if (abort) begin
        m_busy = 0; m_tvalid = 0; m_cnt = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_h = int'(holdoff_len); m_w = int'(window_len); m_thr = int'(n_threshold);
          m_nwin = int'(n_windows); m_tl = int'(trig_len);
          m_idx = 0; m_ovf = 0; m_cnt = 0; m_k = 0; m_busy = 1;
        end
      end else if (m_tvalid) begin
        if (result_tready) begin
          m_tvalid = 0;
          if (m_nwin == 0 || m_idx + 1 < m_nwin) begin
            m_idx = (m_idx + 1) % (1 << IW);
            m_k = 0;
          end else begin
            m_busy = 0;
          end
        end
      end else begin
        m_k++;
        if (m_k > m_h) begin
          if (edge_in) m_cnt++;
          if (m_cnt > CMAX) m_ovf = 1;
          if (m_k == m_h + ((m_w == 0) ? 1 : m_w)) begin
            m_tdata  = (m_cnt > CMAX) ? CMAX : m_cnt;
            m_tvalid = 1;
            m_cnt    = 0;
            m_fire   = (m_thr != 0) && (m_tdata >= m_thr) && (m_tl != 0);
          end
        end
      end
      if (abort)            m_trig = 0;
      else if (m_fire)      m_trig = m_tl;
      else if (m_trig > 0)  m_trig--;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("tvalid", result_tvalid, m_tvalid);
    chk("tdata", result_tdata, m_tdata);
    chk("trig_out", trig_out, m_trig > 0);
    chk("window_idx", window_idx, m_idx);
    chk("overflow", overflow, m_ovf);
  end

  task automatic go(input int h, input int w, input int thr, input int nw, input int tl);
    holdoff_len = h; window_len = w; n_threshold = thr; n_windows = nw; trig_len = tl;
    start = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  int lat, vcnt, tcnt, tfirst, stall;
  int res[$];

  initial begin
    rst = 1'b0; start = 0; abort = 0; edge_in = 0; result_tready = 1;
    window_len = 0; holdoff_len = 0; n_threshold = 0; n_windows = 0; trig_len = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_tvalid", result_tvalid, 0);
    chk("rst_trig", trig_out, 0);
    chk("rst_idx", window_idx, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 3 edges in a 10-cycle gate, result 11 cycles after start.
    go(0, 10, 0, 1, 0);
    lat = 0; vcnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start = 0;
      if (i == 1) begin window_len = 2; holdoff_len = 7; n_windows = 5; end
      if (result_tvalid) begin
        vcnt++;
        if (lat == 0) begin lat = i; chk("t1_tdata", result_tdata, 3); end
      end
      edge_in = (i == 2 || i == 5 || i == 9);
    end
    chk("t1_latency", lat, 11);
    chk("t1_valid_cycles", vcnt, 1);
    chk("t1_busy_end", busy, 0);
    edge_in = 0;
    repeat (3) @(negedge clk);

    // 2: threshold 3, counts 2 then 4; pulse only after the second window.
    go(0, 6, 3, 2, 5);
    tcnt = 0; tfirst = 0; res.delete();
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      start = 0;
      if (result_tvalid) res.push_back(int'(result_tdata));
      if (trig_out) begin tcnt++; if (tfirst == 0) tfirst = i; end
      edge_in = (i == 2 || i == 4 || (i >= 7 && i <= 11));
    end
    chk("t2_nres", res.size(), 2);
    if (res.size() == 2) begin
      chk("t2_res0", res[0], 2);
      chk("t2_res1", res[1], 4);
    end
    chk("t2_trig_cycles", tcnt, 5);
    chk("t2_trig_first", tfirst, 14);
    chk("t2_idx", window_idx, 1);
    edge_in = 0;
    repeat (3) @(negedge clk);

    // 3: ready stalled 20 cycles; stall edges and handshake-edge strobe ignored.
    go(0, 4, 0, 2, 0);
    stall = 0; res.delete();
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = 0;
      if (i >= 5 && i <= 24 && result_tvalid && result_tdata == 1) stall++;
      if (i == 29) begin
        chk("t3_valid2", result_tvalid, 1);
        chk("t3_res2", result_tdata, 2);
      end
      edge_in = (i == 2) || (i >= 5 && i <= 25) || (i == 27);
      result_tready = (i >= 24);
    end
    chk("t3_stall", stall, 20);
    chk("t3_busy_end", busy, 0);
    edge_in = 0; result_tready = 1;
    repeat (3) @(negedge clk);

    // 4: holdoff 4; final-gate edge counted, holdoff edges not.
    go(4, 3, 0, 2, 0);
    res.delete();
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      start = 0;
      if (result_tvalid) res.push_back(int'(result_tdata));
      edge_in = (i == 1 || i == 7 || i == 9 || i == 12 || i == 13);
    end
    chk("t4_nres", res.size(), 2);
    if (res.size() == 2) begin
      chk("t4_res0", res[0], 1);
      chk("t4_res1", res[1], 1);
    end
    edge_in = 0;
    repeat (3) @(negedge clk);

    // 5: saturation to 15, sticky overflow cleared by the next start.
    go(0, 20, 0, 1, 0);
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      start = 0;
      if (i == 21) chk("t5_res", result_tdata, 15);
      edge_in = 1;
    end
    edge_in = 0;
    repeat (3) @(negedge clk);
    chk("t5_ovf_sticky", overflow, 1);
    go(0, 2, 0, 1, 0);
    @(negedge clk);
    start = 0;
    chk("t5_ovf_cleared", overflow, 0);
    repeat (5) @(negedge clk);

    // 6: continuous mode, abort mid-gate with trigger active; start+abort ignored.
    go(0, 3, 1, 0, 30);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      start = 0;
      if (i == 6) chk("t6_trig_before", trig_out, 1);
      if (i == 7) begin
        chk("t6_busy", busy, 0);
        chk("t6_tvalid", result_tvalid, 0);
        chk("t6_trig", trig_out, 0);
        chk("t6_idx", window_idx, 1);
      end
      if (i == 8) chk("t6_start_abort", busy, 0);
      edge_in = (i == 1 || i == 6);
      abort   = (i == 6 || i == 7);
      start   = (i == 6 || i == 7);
    end
    start = 0; abort = 0; edge_in = 0;
    repeat (2) @(negedge clk);
    chk("t6_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
